// File: rtl/paddle_ctrl_accel.sv
// Breakout paddle X controller: frame-tick driven motion with held-button speed ramp
// and exact clamping against both playfield walls.
module paddle_ctrl_accel #(
    parameter int XW          = 9,
    parameter int SCREEN_W    = 320,
    parameter int PAD_W       = 40,
    parameter int X_INIT      = 140,
    parameter int V_MIN       = 1,
    parameter int V_MAX       = 4,
    parameter int ACCEL_TICKS = 8,
    parameter int VW          = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          left,
    input  logic          right,
    output logic [XW-1:0] x_out,
    output logic [VW-1:0] speed,
    output logic [1:0]    dir,
    output logic          at_left,
    output logic          at_right
);

    localparam int XMAX = SCREEN_W - PAD_W;
    localparam int HW   = (ACCEL_TICKS > 1) ? $clog2(ACCEL_TICKS) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LEFT  = 2'b01,
        RIGHT = 2'b10
    } state_t;

    state_t        state;
    state_t        req;
    logic [HW-1:0] hold_cnt;
    logic [HW-1:0] hold_next;
    logic [VW-1:0] speed_next;
    logic [XW-1:0] x_next;
    logic [XW:0]   x_wide;
    logic [XW:0]   s_wide;
    logic [XW:0]   sum_wide;

    // Next-tick values; one extra bit on the position math so nothing wraps.
    always_comb begin
        req = IDLE;
        if (left && !right) begin
            req = LEFT;
        end else if (right && !left) begin
            req = RIGHT;
        end

        hold_next  = '0;
        speed_next = '0;
        x_next     = x_out;
        x_wide     = {1'b0, x_out};
        s_wide     = '0;
        sum_wide   = '0;

        if (req != IDLE) begin
            if (req != state) begin
                speed_next = VW'(V_MIN);
            end else if (hold_cnt == HW'(ACCEL_TICKS - 1)) begin
                speed_next = (speed >= VW'(V_MAX)) ? VW'(V_MAX) : speed + VW'(1);
            end else begin
                hold_next  = hold_cnt + HW'(1);
                speed_next = speed;
            end

            s_wide = (XW + 1)'(speed_next);

            // Hitting or resting on a wall drops back to crawl speed.
            if (req == LEFT) begin
                sum_wide = x_wide - s_wide;
                if ((x_wide < s_wide) || (x_out == '0)) begin
                    x_next     = '0;
                    speed_next = VW'(V_MIN);
                    hold_next  = '0;
                end else begin
                    x_next = sum_wide[XW-1:0];
                end
            end else begin
                sum_wide = x_wide + s_wide;
                if ((sum_wide > (XW + 1)'(XMAX)) || (x_out == XW'(XMAX))) begin
                    x_next     = XW'(XMAX);
                    speed_next = VW'(V_MIN);
                    hold_next  = '0;
                end else begin
                    x_next = sum_wide[XW-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            x_out    <= XW'(X_INIT);
            speed    <= '0;
            hold_cnt <= '0;
        end else if (en) begin
            state    <= req;
            x_out    <= x_next;
            speed    <= speed_next;
            hold_cnt <= hold_next;
        end
    end

    assign dir      = state;
    assign at_left  = (x_out == '0);
    assign at_right = (x_out == XW'(XMAX));

endmodule
